// File: rtl/cpu_pkg.sv
// Shared fetch/decode types: PC and instruction widths, NOP encoding and the
// packed IF/ID entry carried through the fetch queue.
package cpu_pkg;
  localparam int ADDR_WIDTH = 64;
  localparam int INST_WIDTH = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc4;
    logic [INST_WIDTH-1:0] inst;
  } if_id_entry_t;
endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue bus: enqueue side from fetch, dequeue side to decode,
// plus flush and occupancy status. The queue itself uses the slave modport.
interface if_id_queue_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  enq_valid;
  logic                  enq_ready;
  logic [ADDR_WIDTH-1:0] enq_pc;
  logic [ADDR_WIDTH-1:0] enq_pc4;
  logic [INST_WIDTH-1:0] enq_inst;
  logic                  deq_valid;
  logic                  deq_ready;
  logic [ADDR_WIDTH-1:0] deq_pc;
  logic [ADDR_WIDTH-1:0] deq_pc4;
  logic [INST_WIDTH-1:0] deq_inst;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;

  modport slave (
    input  flush, enq_valid, enq_pc, enq_pc4, enq_inst, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_pc4, deq_inst, count, empty, full
  );

  modport master (
    output flush, enq_valid, enq_pc, enq_pc4, enq_inst, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_pc4, deq_inst, count, empty, full
  );
endinterface

// File: rtl/if_id_queue_storage.sv
// Entry storage for the IF/ID queue: register array, one synchronous write
// port and one asynchronous read port. Not reset; validity lives in the
// pointer/count logic of the parent.
module ifq_storage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [PW-1:0] waddr,
  input  if_id_entry_t wdata,
  input  logic [PW-1:0] raddr,
  output if_id_entry_t rdata
);
  if_id_entry_t mem [DEPTH];

  // write the pushed entry into its slot
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// IF/ID fetch queue: DEPTH-entry FIFO between fetch and decode with flush,
// synchronous active-high reset and a NOP/zero head when empty.
// Optional feature: IF_ID_QUEUE_BYPASS_EN lets an entry arriving at an empty
// queue appear at the head in the same cycle (and skip storage if consumed).
// Entry field widths come from cpu_pkg; ADDR_WIDTH/INST_WIDTH must match it.
module if_id_queue
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int INST_WIDTH = cpu_pkg::INST_WIDTH,
  parameter int DEPTH      = 4
) (
  input logic clk,
  input logic reset,
  if_id_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic          full_i, empty_i, push, pop, head_valid;
  if_id_entry_t  wr_entry, rd_entry, head;

  assign full_i  = (cnt == (PW+1)'(DEPTH));
  assign empty_i = (cnt == '0);

  // pack the enqueue fields into a storage entry
  always_comb begin
    wr_entry      = '0;
    wr_entry.pc   = q.enq_pc;
    wr_entry.pc4  = q.enq_pc4;
    wr_entry.inst = q.enq_inst;
  end

  // Ready is purely !full: a pop in the same cycle never frees a slot.
  assign pop = !empty_i && q.deq_ready;

`ifdef IF_ID_QUEUE_BYPASS_EN
  logic byp;
  assign byp        = empty_i && q.enq_valid && !q.flush;
  assign push       = q.enq_valid && !full_i && !(byp && q.deq_ready);
  assign head_valid = !empty_i || byp;
  assign head       = byp ? wr_entry : rd_entry;
`else
  assign push       = q.enq_valid && !full_i;
  assign head_valid = !empty_i;
  assign head       = rd_entry;
`endif

  ifq_storage #(.DEPTH(DEPTH)) u_store (
    .clk   (clk),
    .we    (push && !q.flush && !reset),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // pointers wrap naturally (DEPTH is a power of two); reset > flush > push/pop
  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign q.enq_ready = !full_i;
  assign q.deq_valid = head_valid;
  assign q.deq_pc    = head_valid ? ADDR_WIDTH'(head.pc)   : '0;
  assign q.deq_pc4   = head_valid ? ADDR_WIDTH'(head.pc4)  : '0;
  assign q.deq_inst  = head_valid ? INST_WIDTH'(head.inst) : INST_WIDTH'(NOP);
  assign q.count     = cnt;
  assign q.empty     = empty_i;
  assign q.full      = full_i;
endmodule
